// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage and the load lane aligner.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_REQ   = 2'd1,
    WB_WAIT  = 2'd2,
    WB_WRITE = 2'd3
  } wb_state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Replicates the sign bit of a narrow value into a 32-bit word.
  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic is_unsigned);
    ext_byte = is_unsigned ? {24'h00_0000, b} : {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic is_unsigned);
    ext_half = is_unsigned ? {16'h0000, h} : {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/writeback_unit_load_align.sv
// Combinational lane select and sign/zero extension of a loaded word.
// Shared with the LSU, so it carries no state of its own.
import wb_pkg::*;

module load_align (
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_bytes,
  input  logic        i_unsigned,
  output logic [31:0] o_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte/half lane and extend it to a full word.
  always_comb begin
    w_byte  = 8'h00;
    w_half  = 16'h0000;
    o_value = 32'h0000_0000;
    case (i_addr)
      2'b00:   w_byte = i_rdata[7:0];
      2'b01:   w_byte = i_rdata[15:8];
      2'b10:   w_byte = i_rdata[23:16];
      2'b11:   w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    if (i_addr[1]) begin
      w_half = i_rdata[31:16];
    end else begin
      w_half = i_rdata[15:0];
    end
    case (i_bytes)
      SZ_BYTE: o_value = ext_byte(w_byte, i_unsigned);
      SZ_HALF: o_value = ext_half(w_half, i_unsigned);
      SZ_WORD: o_value = i_rdata;
      default: o_value = i_rdata;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: writes ALU results straight to the register file and
// runs loads through a request/response handshake before writing them back.
import wb_pkg::*;

module writeback_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic                  ex_reg_we,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_to_reg,
  input  logic [XLEN-1:0]       ex_result,
  input  logic [1:0]            ex_bytes,
  input  logic                  ex_unsigned,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [XLEN-1:0]       mem_addr,
  input  logic                  mem_rsp_valid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic                  reg_we,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       reg_wdata,
  output logic                  busy
);

  wb_state_t             r_state;
  logic                  r_reg_we;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [1:0]            r_lane;
  logic [1:0]            r_bytes;
  logic                  r_unsigned;
  logic [XLEN-1:0]       r_mem_addr;
  logic [XLEN-1:0]       r_wdata;
  logic                  r_rsp_seen;

  logic                  w_accept;
  logic [XLEN-1:0]       w_load_data;

  load_align u_load_align (
    .i_rdata    (mem_rdata),
    .i_addr     (r_lane),
    .i_bytes    (r_bytes),
    .i_unsigned (r_unsigned),
    .o_value    (w_load_data)
  );

  // Output decode from the state register; only run gates the handshakes.
  always_comb begin
    ex_ready      = reset & run & ((r_state == WB_IDLE) | (r_state == WB_WRITE));
    w_accept      = ex_valid & ex_ready;
    mem_req_valid = (r_state == WB_REQ);
    busy          = (r_state != WB_IDLE);
    reg_we        = (r_state == WB_WRITE) & run & r_reg_we & (r_rd != {REG_ADDR_W{1'b0}});
    rd            = r_rd;
    mem_addr      = r_mem_addr;
    reg_wdata     = r_wdata;
  end

  // Writeback FSM and the latched copy of the accepted op.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= WB_IDLE;
      r_reg_we   <= 1'b0;
      r_rd       <= {REG_ADDR_W{1'b0}};
      r_lane     <= 2'b00;
      r_bytes    <= SZ_BYTE;
      r_unsigned <= 1'b0;
      r_mem_addr <= {XLEN{1'b0}};
      r_wdata    <= {XLEN{1'b0}};
      r_rsp_seen <= 1'b0;
    end else begin
      if (w_accept) begin
        r_reg_we   <= ex_reg_we;
        r_rd       <= ex_rd;
        r_lane     <= ex_result[1:0];
        r_bytes    <= ex_bytes;
        r_unsigned <= ex_unsigned;
        r_rsp_seen <= 1'b0;
        if (ex_mem_to_reg) begin
          r_mem_addr <= {ex_result[XLEN-1:2], 2'b00};
        end else begin
          r_wdata <= ex_result;
        end
      end
      case (r_state)
        WB_IDLE: begin
          if (w_accept) begin
            r_state <= ex_mem_to_reg ? WB_REQ : WB_WRITE;
          end
        end
        // The request is already visible to memory, so it completes even with run low.
        WB_REQ: begin
          if (mem_req_ready) begin
            r_state <= WB_WAIT;
          end
        end
        // First response is kept; r_rsp_seen remembers it while run is low.
        WB_WAIT: begin
          if (mem_rsp_valid && !r_rsp_seen) begin
            r_wdata    <= w_load_data;
            r_rsp_seen <= 1'b1;
          end
          if (run && (mem_rsp_valid || r_rsp_seen)) begin
            r_state <= WB_WRITE;
          end
        end
        WB_WRITE: begin
          if (run) begin
            if (w_accept) begin
              r_state <= ex_mem_to_reg ? WB_REQ : WB_WRITE;
            end else begin
              r_state <= WB_IDLE;
            end
          end
        end
        default: r_state <= WB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with hand-computed expectations.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset, run, ex_valid, ex_ready, ex_reg_we, ex_mem_to_reg, ex_unsigned;
  logic [4:0]  ex_rd, rd;
  logic [31:0] ex_result, mem_addr, mem_rdata, reg_wdata;
  logic [1:0]  ex_bytes;
  logic        mem_req_valid, mem_req_ready, mem_rsp_valid, reg_we, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk(clk), .reset(reset), .run(run),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_reg_we(ex_reg_we), .ex_rd(ex_rd),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_result(ex_result), .ex_bytes(ex_bytes),
    .ex_unsigned(ex_unsigned), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .reg_we(reg_we), .rd(rd), .reg_wdata(reg_wdata), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_op(input logic [4:0] r, input logic [31:0] v);
    ex_valid = 1'b1; ex_reg_we = 1'b1; ex_rd = r; ex_mem_to_reg = 1'b0; ex_result = v;
  endtask

  task automatic do_load(input string tag, input logic [4:0] r, input logic [31:0] addr,
                         input logic [1:0] sz, input logic uns, input logic [31:0] rdata,
                         input int stall, input logic [31:0] exp_addr, input logic [31:0] exp_data);
    ex_valid = 1'b1; ex_reg_we = 1'b1; ex_rd = r; ex_mem_to_reg = 1'b1;
    ex_result = addr; ex_bytes = sz; ex_unsigned = uns;
    tick();
    ex_valid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      chk({tag, "_stall_valid"}, mem_req_valid, 32'd1);
      chk({tag, "_stall_addr"}, mem_addr, exp_addr);
      chk({tag, "_stall_ready"}, ex_ready, 32'd0);
      mem_rsp_valid = 1'b1; mem_rdata = 32'hDEAD_DEAD;
      tick();
    end
    mem_rsp_valid = 1'b0;
    chk({tag, "_req_valid"}, mem_req_valid, 32'd1);
    chk({tag, "_addr"}, mem_addr, exp_addr);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk({tag, "_wait_valid"}, mem_req_valid, 32'd0);
    chk({tag, "_wait_we"}, reg_we, 32'd0);
    mem_rsp_valid = 1'b1; mem_rdata = rdata;
    tick();
    mem_rsp_valid = 1'b0; mem_rdata = 32'h5555_AAAA;
    chk({tag, "_we"}, reg_we, 32'd1);
    chk({tag, "_rd"}, rd, {27'd0, r});
    chk({tag, "_wdata"}, reg_wdata, exp_data);
    tick();
    chk({tag, "_idle"}, busy, 32'd0);
  endtask

  initial begin
    reset = 1'b0; run = 1'b1; ex_valid = 1'b0; ex_reg_we = 1'b0; ex_rd = 5'd0;
    ex_mem_to_reg = 1'b0; ex_result = 32'd0; ex_bytes = 2'b00; ex_unsigned = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'd0;
    tick(); tick();
    chk("rst_ready", ex_ready, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_we", reg_we, 32'd0);
    chk("rst_req", mem_req_valid, 32'd0);
    chk("rst_rd", rd, 32'd0);
    chk("rst_wdata", reg_wdata, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_ready", ex_ready, 32'd1);

    // Back-to-back ALU ops.
    alu_op(5'd5, 32'h1234_5678);
    tick();
    chk("alu1_we", reg_we, 32'd1);
    chk("alu1_rd", rd, 32'd5);
    chk("alu1_wdata", reg_wdata, 32'h1234_5678);
    alu_op(5'd6, 32'hA5A5_0001);
    tick();
    ex_valid = 1'b0;
    chk("alu2_we", reg_we, 32'd1);
    chk("alu2_rd", rd, 32'd6);
    chk("alu2_wdata", reg_wdata, 32'hA5A5_0001);
    tick();
    chk("alu_done_we", reg_we, 32'd0);
    chk("alu_done_busy", busy, 32'd0);

    do_load("lb_s", 5'd7, 32'h0000_0103, 2'b00, 1'b0, 32'h8000_0000, 0, 32'h0000_0100, 32'hFFFF_FF80);
    do_load("lb_u", 5'd7, 32'h0000_0103, 2'b00, 1'b1, 32'h8000_0000, 0, 32'h0000_0100, 32'h0000_0080);
    do_load("lhu", 5'd8, 32'h0000_0202, 2'b01, 1'b1, 32'hBEEF_0000, 3, 32'h0000_0200, 32'h0000_BEEF);
    do_load("lh_s", 5'd9, 32'h0000_0301, 2'b01, 1'b0, 32'h0000_8001, 1, 32'h0000_0300, 32'hFFFF_8001);
    do_load("lbu1", 5'd10, 32'h0000_0401, 2'b00, 1'b1, 32'h0000_AB00, 0, 32'h0000_0400, 32'h0000_00AB);
    do_load("lw", 5'd11, 32'h0000_0503, 2'b10, 1'b0, 32'h8765_4321, 0, 32'h0000_0500, 32'h8765_4321);
    do_load("lw11", 5'd12, 32'h0000_0604, 2'b11, 1'b0, 32'hCAFE_F00D, 0, 32'h0000_0604, 32'hCAFE_F00D);

    // Write to x0 is consumed without a write enable.
    alu_op(5'd0, 32'h0000_DEAD);
    tick();
    ex_valid = 1'b0;
    chk("x0_we", reg_we, 32'd0);
    chk("x0_ready", ex_ready, 32'd1);
    tick();
    chk("x0_busy", busy, 32'd0);

    // Reset while waiting for a response; the late response is dropped.
    ex_valid = 1'b1; ex_reg_we = 1'b1; ex_rd = 5'd13; ex_mem_to_reg = 1'b1;
    ex_result = 32'h0000_0700; ex_bytes = 2'b10;
    tick();
    ex_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("rw_busy", busy, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_rsp_valid = 1'b0;
    chk("rw_we", reg_we, 32'd0);
    chk("rw_busy_after", busy, 32'd0);
    chk("rw_rd", rd, 32'd0);
    chk("rw_wdata", reg_wdata, 32'd0);
    chk("rw_addr", mem_addr, 32'd0);
    tick();
    chk("rw_we2", reg_we, 32'd0);

    // run=0 in IDLE blocks acceptance.
    run = 1'b0;
    #1;
    chk("idle_stall_ready", ex_ready, 32'd0);
    run = 1'b1;

    // run=0 during WRITE holds the write until run returns.
    alu_op(5'd9, 32'h0BAD_F00D);
    tick();
    ex_valid = 1'b0; run = 1'b0;
    #1;
    chk("frz_we0", reg_we, 32'd0);
    tick();
    chk("frz_we1", reg_we, 32'd0);
    chk("frz_busy", busy, 32'd1);
    chk("frz_ready", ex_ready, 32'd0);
    tick();
    chk("frz_we2", reg_we, 32'd0);
    run = 1'b1;
    #1;
    chk("frz_we", reg_we, 32'd1);
    chk("frz_rd", rd, 32'd9);
    chk("frz_wdata", reg_wdata, 32'h0BAD_F00D);
    tick();
    chk("frz_single", reg_we, 32'd0);
    chk("frz_idle", busy, 32'd0);

    // run=0 in WAIT still captures the first response; a second one is ignored.
    ex_valid = 1'b1; ex_reg_we = 1'b1; ex_rd = 5'd14; ex_mem_to_reg = 1'b1;
    ex_result = 32'h0000_0802; ex_bytes = 2'b01; ex_unsigned = 1'b0;
    tick();
    ex_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; run = 1'b0;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h7ABC_0000;
    tick();
    mem_rdata = 32'h0000_1111;
    chk("wfrz_we", reg_we, 32'd0);
    chk("wfrz_busy", busy, 32'd1);
    tick();
    mem_rsp_valid = 1'b0; run = 1'b1;
    tick();
    chk("wfrz_wr_we", reg_we, 32'd1);
    chk("wfrz_wr_rd", rd, 32'd14);
    chk("wfrz_wr_wdata", reg_wdata, 32'h0000_7ABC);
    tick();
    chk("wfrz_idle", busy, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
